multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready/req handshakes to instruction and data memory.
- Drives datapath enables (ir_write, pc_write, reg_write), ALU/immediate selects and memory strobes.
- Flags illegal opcodes and memory timeouts, then halts in TRAP.

Parameters:
- WAIT_LIMIT, 16, max cycles FETCH or MEM waits for ready before bus error; 0 disables timeout.
- CNT_W, 5, width of wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from external instruction register
- func3  in  3  instr[14:12]
- func7  in  7  instr[31:25]
- alu_zero  in  1  ALU result == 0
- alu_last_bit  in  1  ALU result bit 0 (SLT/SLTU outcome)
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_source  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result & ~1 (JALR)
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASS_B
- alu_source  out  1  0 rs2, 1 immediate
- alu_a_pc  out  1  ALU operand A = PC (AUIPC)
- imm_source  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- mem_read  out  1  data read strobe
- mem_write  out  1  data write strobe
- result_source  out  2  00 ALU, 01 memory, 10 PC+4
- reg_write  out  1  register file write enable
- illegal_instr  out  1  sticky, unsupported opcode seen
- bus_error  out  1  sticky, memory wait exceeded WAIT_LIMIT
- halted  out  1  state == TRAP

Behaviour:
- Reset (rst_n low, async): state=FETCH, wait counter=0, sticky flags=0. All outputs 0 while rst_n low; imem_req=1 first cycle after release.
- Outputs decode combinationally from registered state plus op/func3/func7. Fields are stable from DECODE onward because the IR only loads on ir_write.
- FETCH: imem_req=1. imem_ready=1 -> ir_write=1, next DECODE. Else stay and increment counter.
- DECODE: one cycle; imm_source valid. Supported op: 0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other op -> TRAP, illegal_instr set.
- EXEC:
  - R/I-ALU: alu_control from func3; func7[5] selects SUB/SRA (SUB only when op=0110011). Next WB.
  - Load/store: ADD, alu_source=1. Next MEM.
  - Branch: BEQ/BNE use SUB with alu_zero; BLT/BGE use SLT, BLTU/BGEU use SLTU with alu_last_bit. func3 010/011 is illegal -> TRAP. pc_write=1 with pc_source=01 if taken, else 00. Next FETCH.
  - JAL, JALR, LUI (PASS_B), AUIPC (ADD, alu_a_pc=1): next WB.
- MEM: mem_read (load) or mem_write (store) held until dmem_ready. Counter increments each waiting cycle. On ready: load -> WB; store -> pc_write=1 (pc_source=00) -> FETCH.
- WB: reg_write=1, pc_write=1, result_source 01 load / 10 JAL,JALR / 00 otherwise; pc_source 01 JAL, 10 JALR, else 00. Next FETCH.
- Timeout: counter clears on each state entry. Reaching WAIT_LIMIT in FETCH/MEM without ready -> TRAP, bus_error set. Ready on the WAIT_LIMIT cycle itself wins.
- TRAP: all strobes/enables 0; stays until reset.
- Latency (zero wait): ALU/LUI/AUIPC/JAL 4 cycles, branch 3, store 4, load 5.
- Reset mid-MEM drops strobes immediately; no write completes.

Test Plan:
- Reset, imem_ready=1 on cycle 1, op=0110011 func3=000 func7=0100000 -> ir_write cycle1, EXEC alu_control=0001, reg_write cycle4, result_source=00.
- Load op=0000011, dmem_ready delayed 3 cycles -> mem_read held 4 cycles, WB result_source=01, 8 cycles total.
- BNE func3=001 alu_zero=0 -> EXEC pc_write=1 pc_source=01; repeat alu_zero=1 -> pc_source=00.
- JALR op=1100111 -> WB reg_write=1, result_source=10, pc_source=10.
- op=1111111 -> TRAP after DECODE, illegal_instr=1, halted=1; all strobes 0 for 20 cycles.
- WAIT_LIMIT=4, imem_ready held 0 -> bus_error=1 at 4th FETCH cycle; rst_n low mid-MEM store -> mem_write drops same cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// ready handshakes, drives datapath enables/selects, and halts in TRAP on faults.
module multicycle_control #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       alu_zero,
   input  logic       alu_last_bit,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_source,
   output logic [3:0] alu_control,
   output logic       alu_source,
   output logic       alu_a_pc,
   output logic [2:0] imm_source,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] result_source,
   output logic       reg_write,
   output logic       illegal_instr,
   output logic       bus_error,
   output logic       halted
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND = 4'b0010,
                          ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101,
                          ALU_SRL  = 4'b0110, ALU_SRA  = 4'b0111, ALU_SLT = 4'b1000,
                          ALU_SLTU = 4'b1001, ALU_PASSB = 4'b1010;

   localparam logic [CNT_W-1:0] LIMIT_M1   = CNT_W'(WAIT_LIMIT - 1);
   localparam bit               TIMEOUT_EN = (WAIT_LIMIT != 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   logic is_load, is_store, is_r, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc, legal_op;
   logic expired, br_taken, br_legal;
   logic [3:0] alu_fn;
   logic [2:0] imm_sel;
   logic       unused_func7;

   logic       imem_req_c, ir_write_c, pc_write_c, alu_source_c, alu_a_pc_c;
   logic       mem_read_c, mem_write_c, reg_write_c;
   logic [1:0] pc_source_c, result_source_c;
   logic [3:0] alu_control_c;
   logic [2:0] imm_source_c;

   assign is_load  = (op == OP_LOAD);
   assign is_store = (op == OP_STORE);
   assign is_r     = (op == OP_R);
   assign is_i     = (op == OP_I);
   assign is_br    = (op == OP_BR);
   assign is_jal   = (op == OP_JAL);
   assign is_jalr  = (op == OP_JALR);
   assign is_lui   = (op == OP_LUI);
   assign is_auipc = (op == OP_AUIPC);
   assign legal_op = is_load | is_store | is_r | is_i | is_br | is_jal | is_jalr | is_lui | is_auipc;
   assign unused_func7 = ^{func7[6], func7[4:0]};

   // Last permitted waiting cycle; ready in this same cycle still proceeds
   assign expired  = TIMEOUT_EN && (cnt_q == LIMIT_M1);
   assign br_legal = (func3[2:1] != 2'b01);

   always_comb begin
      br_taken = 1'b0;
      case (func3)
         3'b000:         br_taken = alu_zero;
         3'b001:         br_taken = ~alu_zero;
         3'b100, 3'b110: br_taken = alu_last_bit;
         3'b101, 3'b111: br_taken = ~alu_last_bit;
         default:        br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_fn = ALU_ADD;
      if (is_r || is_i) begin
         case (func3)
            3'b000:  alu_fn = (is_r && func7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = func7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
         endcase
      end else if (is_br) begin
         alu_fn = !func3[2] ? ALU_SUB : (func3[1] ? ALU_SLTU : ALU_SLT);
      end else if (is_lui) begin
         alu_fn = ALU_PASSB;
      end
   end

   always_comb begin
      imm_sel = 3'b000;
      if (is_store)                imm_sel = 3'b001;
      else if (is_br)              imm_sel = 3'b010;
      else if (is_lui || is_auipc) imm_sel = 3'b011;
      else if (is_jal)             imm_sel = 3'b100;
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = '0;
      illegal_d       = illegal_q;
      bus_err_d       = bus_err_q;
      imem_req_c      = 1'b0;
      ir_write_c      = 1'b0;
      pc_write_c      = 1'b0;
      pc_source_c     = '0;
      alu_control_c   = '0;
      alu_source_c    = 1'b0;
      alu_a_pc_c      = 1'b0;
      imm_source_c    = '0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      result_source_c = '0;
      reg_write_c     = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ready) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (expired) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            imm_source_c = imm_sel;
            if (legal_op) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            imm_source_c  = imm_sel;
            alu_control_c = alu_fn;
            alu_source_c  = ~(is_r | is_br);
            alu_a_pc_c    = is_auipc;
            if (is_br) begin
               if (br_legal) begin
                  pc_write_c  = 1'b1;
                  pc_source_c = br_taken ? 2'b01 : 2'b00;
                  state_d     = S_FETCH;
               end else begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            imm_source_c  = imm_sel;
            alu_control_c = alu_fn;
            alu_source_c  = 1'b1;
            mem_read_c    = is_load;
            mem_write_c   = is_store;
            if (dmem_ready) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  pc_write_c = 1'b1;
                  state_d    = S_FETCH;
               end
            end else if (expired) begin
               state_d   = S_TRAP;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            imm_source_c    = imm_sel;
            reg_write_c     = 1'b1;
            pc_write_c      = 1'b1;
            result_source_c = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
            pc_source_c     = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
            state_d         = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Gating with rst_n makes every output drop the instant reset asserts
   assign imem_req      = rst_n & imem_req_c;
   assign ir_write      = rst_n & ir_write_c;
   assign pc_write      = rst_n & pc_write_c;
   assign pc_source     = rst_n ? pc_source_c : '0;
   assign alu_control   = rst_n ? alu_control_c : '0;
   assign alu_source    = rst_n & alu_source_c;
   assign alu_a_pc      = rst_n & alu_a_pc_c;
   assign imm_source    = rst_n ? imm_source_c : '0;
   assign mem_read      = rst_n & mem_read_c;
   assign mem_write     = rst_n & mem_write_c;
   assign result_source = rst_n ? result_source_c : '0;
   assign reg_write     = rst_n & reg_write_c;
   assign illegal_instr = rst_n & illegal_q;
   assign bus_error     = rst_n & bus_err_q;
   assign halted        = rst_n & (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions checked cycle by
// cycle against an instruction-level model of the expected control sequence.
module tb_multicycle_control;
   localparam int WL = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op, func7;
   logic [2:0] func3;
   logic       alu_zero, alu_last_bit, imem_ready, dmem_ready;
   logic       imem_req, ir_write, pc_write, alu_source, alu_a_pc;
   logic       mem_read, mem_write, reg_write, illegal_instr, bus_error, halted;
   logic [1:0] pc_source, result_source;
   logic [3:0] alu_control;
   logic [2:0] imm_source;

   always #5 clk = ~clk;

   multicycle_control #(.WAIT_LIMIT(WL), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
      .alu_zero(alu_zero), .alu_last_bit(alu_last_bit),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_source(pc_source), .alu_control(alu_control), .alu_source(alu_source),
      .alu_a_pc(alu_a_pc), .imm_source(imm_source), .mem_read(mem_read),
      .mem_write(mem_write), .result_source(result_source), .reg_write(reg_write),
      .illegal_instr(illegal_instr), .bus_error(bus_error), .halted(halted)
   );

   typedef struct packed {
      logic       imem_req, ir_write, pc_write;
      logic [1:0] pc_source;
      logic [3:0] alu_control;
      logic       alu_source, alu_a_pc;
      logic [2:0] imm_source;
      logic       mem_read, mem_write;
      logic [1:0] result_source;
      logic       reg_write, illegal_instr, bus_error, halted;
   } out_t;

   typedef enum int {C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                          A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9,
                          A_PASSB = 4'd10;
   localparam out_t ALL = '1;

   out_t obs;
   assign obs = out_t'({imem_req, ir_write, pc_write, pc_source, alu_control, alu_source,
                        alu_a_pc, imm_source, mem_read, mem_write, result_source, reg_write,
                        illegal_instr, bus_error, halted});

   int   tests = 0, fails = 0;
   logic exp_ill = 1'b0, exp_bus = 1'b0;
   logic [3:0] alu_by_f3 [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};

   function automatic cls_t classify(input logic [6:0] o);
      case (o)
         7'b0000011: return C_LOAD;
         7'b0100011: return C_STORE;
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         7'b0110111: return C_LUI;
         7'b0010111: return C_AUIPC;
         default:    return C_ILL;
      endcase
   endfunction

   function automatic logic [2:0] imm_of(input cls_t c);
      case (c)
         C_STORE:         return 3'b001;
         C_BR:            return 3'b010;
         C_LUI, C_AUIPC:  return 3'b011;
         C_JAL:           return 3'b100;
         default:         return 3'b000;
      endcase
   endfunction

   function automatic out_t flags();
      out_t e = '0;
      e.illegal_instr = exp_ill;
      e.bus_error     = exp_bus;
      return e;
   endfunction

   function automatic out_t smask();
      out_t m = '0;
      m.imem_req = 1'b1; m.ir_write = 1'b1; m.pc_write = 1'b1; m.mem_read = 1'b1;
      m.mem_write = 1'b1; m.reg_write = 1'b1; m.illegal_instr = 1'b1;
      m.bus_error = 1'b1; m.halted = 1'b1;
      return m;
   endfunction

   task automatic check(input string tag, input out_t e, input out_t m);
      logic [21:0] o, x;
      o = obs & m;
      x = e & m;
      tests++;
      assert (o === x) else begin
         fails++;
         $error("FAIL %s: observed %h, required %h", tag, o, x);
      end
   endtask

   task automatic noise();
      imem_ready   = 1'($urandom);
      dmem_ready   = 1'($urandom);
      alu_zero     = 1'($urandom);
      alu_last_bit = 1'($urandom);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      noise();
      imem_ready = 1'b1;
      #1 check("reset_now", '0, ALL);
      @(posedge clk);
      #1 check("reset_hold", '0, ALL);
      @(posedge clk);
      #2 rst_n = 1'b1;
      exp_ill = 1'b0;
      exp_bus = 1'b0;
   endtask

   task automatic trap_check(input int n);
      out_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         noise();
         imem_ready = 1'b1;
         dmem_ready = 1'b1;
         op = 7'($urandom);
         #1;
         e = flags();
         e.halted = 1'b1;
         check("trap", e, smask());
      end
   endtask

   // One instruction from FETCH to its return to FETCH (or a trap)
   task automatic run_instr(input logic [6:0] iop, input logic [2:0] f3, input logic [6:0] f7,
                            input int fdel, input int mdel, input logic [31:0] a,
                            input logic [31:0] b, input int abort_at, output bit trapped);
      cls_t c;
      out_t e, m;
      bit   taken;
      c = classify(iop);
      trapped = 1'b0;
      for (int k = 0; k <= WL; k++) begin
         @(negedge clk);
         noise();
         op = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
         imem_ready = (k == fdel);
         #1;
         e = flags(); e.imem_req = 1'b1; e.ir_write = (k == fdel);
         check("fetch", e, smask());
         if (k == fdel) break;
         if (k == WL - 1) begin exp_bus = 1'b1; trapped = 1'b1; return; end
      end
      @(negedge clk);
      noise();
      op = iop; func3 = f3; func7 = f7;
      #1;
      e = flags(); m = smask();
      if (c != C_ILL && c != C_R) begin e.imm_source = imm_of(c); m.imm_source = '1; end
      check("decode", e, m);
      if (c == C_ILL) begin exp_ill = 1'b1; trapped = 1'b1; return; end
      @(negedge clk);
      noise();
      taken = 1'b0;
      e = flags(); m = smask();
      m.alu_a_pc = 1'b1; e.alu_a_pc = (c == C_AUIPC);
      case (c)
         C_R, C_I: begin
            e.alu_control = alu_by_f3[f3];
            if (f3 == 3'd0 && c == C_R && f7[5]) e.alu_control = A_SUB;
            if (f3 == 3'd5 && f7[5]) e.alu_control = A_SRA;
            e.alu_source = (c == C_I);
         end
         C_LOAD, C_STORE, C_JALR, C_AUIPC: begin e.alu_control = A_ADD; e.alu_source = 1'b1; end
         C_LUI: begin e.alu_control = A_PASSB; e.alu_source = 1'b1; end
         C_BR: begin
            case (f3)
               3'd0: begin taken = (a == b); e.alu_control = A_SUB; end
               3'd1: begin taken = (a != b); e.alu_control = A_SUB; end
               3'd4: begin taken = ($signed(a) < $signed(b));  e.alu_control = A_SLT; end
               3'd5: begin taken = ($signed(a) >= $signed(b)); e.alu_control = A_SLT; end
               3'd6: begin taken = (a < b);  e.alu_control = A_SLTU; end
               3'd7: begin taken = (a >= b); e.alu_control = A_SLTU; end
               default: taken = 1'b0;
            endcase
            // Present the flags a real ALU would produce for that operation
            if (e.alu_control == A_SUB) begin
               alu_zero = ((a - b) == 32'd0); alu_last_bit = a[0] ^ b[0];
            end else begin
               alu_last_bit = taken ^ f3[0]; alu_zero = ~alu_last_bit;
            end
            if (f3 != 3'd2 && f3 != 3'd3) begin
               e.pc_write = 1'b1; e.pc_source = taken ? 2'b01 : 2'b00; m.pc_source = '1;
            end
         end
         default: ;
      endcase
      if (c != C_JAL && !(c == C_BR && (f3 == 3'd2 || f3 == 3'd3))) begin
         m.alu_control = '1;
         if (c != C_BR) m.alu_source = 1'b1;
      end
      #1 check("exec", e, m);
      if (c == C_BR) begin
         if (f3 == 3'd2 || f3 == 3'd3) begin exp_ill = 1'b1; trapped = 1'b1; end
         return;
      end
      if (c == C_LOAD || c == C_STORE) begin
         for (int k = 0; k <= WL; k++) begin
            @(negedge clk);
            noise();
            dmem_ready = (k == mdel);
            #1;
            e = flags(); m = smask();
            e.mem_read = (c == C_LOAD); e.mem_write = (c == C_STORE);
            if (k == mdel && c == C_STORE) begin e.pc_write = 1'b1; m.pc_source = '1; end
            check("mem", e, m);
            if (k == abort_at) begin
               rst_n = 1'b0;
               #1 check("mem_reset", '0, ALL);
               trapped = 1'b1;
               return;
            end
            if (k == mdel) break;
            if (k == WL - 1) begin exp_bus = 1'b1; trapped = 1'b1; return; end
         end
         if (c == C_STORE) return;
      end
      @(negedge clk);
      noise();
      #1;
      e = flags(); m = smask();
      e.reg_write = 1'b1; e.pc_write = 1'b1;
      e.result_source = (c == C_LOAD) ? 2'b01 : ((c == C_JAL || c == C_JALR) ? 2'b10 : 2'b00);
      e.pc_source = (c == C_JAL) ? 2'b01 : ((c == C_JALR) ? 2'b10 : 2'b00);
      m.result_source = '1; m.pc_source = '1;
      check("wb", e, m);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         tr;
      logic [6:0] rop, rf7;
      logic [2:0] rf3;
      logic [31:0] ra, rb;
      int         fd, md;
      logic [6:0] opc [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      rst_n = 1'b0;
      op = '0; func3 = '0; func7 = '0;
      alu_zero = 1'b0; alu_last_bit = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      do_reset();

      run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0, -1, tr);
      run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3, 0, 0, -1, tr);
      run_instr(7'b1100011, 3'b001, 7'b0000000, 0, 0, 32'd5, 32'd7, -1, tr);
      run_instr(7'b1100011, 3'b001, 7'b0000000, 0, 0, 32'd9, 32'd9, -1, tr);
      run_instr(7'b1100111, 3'b000, 7'b0000000, 1, 0, 0, 0, -1, tr);
      run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0, 0, 0, -1, tr);
      run_instr(7'b0110111, 3'b000, 7'b0000000, 2, 0, 0, 0, -1, tr);
      run_instr(7'b0010111, 3'b000, 7'b0000000, WL - 1, 0, 0, 0, -1, tr);
      run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, 0, -1, tr);
      run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 0, -1, tr);
      run_instr(7'b1100011, 3'b100, 7'b0000000, 0, 0, 32'hFFFF_FFFF, 32'd1, -1, tr);
      run_instr(7'b1100011, 3'b110, 7'b0000000, 0, 0, 32'hFFFF_FFFF, 32'd1, -1, tr);

      run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, 0, -1, tr);
      trap_check(20);
      do_reset();
      run_instr(7'b0110011, 3'b000, 7'b0000000, 9, 0, 0, 0, -1, tr);
      trap_check(3);
      do_reset();
      run_instr(7'b0000011, 3'b000, 7'b0000000, 0, 9, 0, 0, -1, tr);
      trap_check(3);
      do_reset();
      run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 9, 0, 0, 1, tr);
      do_reset();
      run_instr(7'b0110011, 3'b111, 7'b0000000, 0, 0, 0, 0, -1, tr);
      run_instr(7'b1100011, 3'b011, 7'b0000000, 0, 0, 0, 0, -1, tr);
      trap_check(3);
      do_reset();

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 11) == 0) begin
            do rop = 7'($urandom); while (classify(rop) != C_ILL);
         end else begin
            rop = opc[$urandom_range(0, 8)];
         end
         rf3 = 3'($urandom);
         rf7 = 7'($urandom);
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         fd  = ($urandom_range(0, 9) == 0) ? WL : $urandom_range(0, WL - 1);
         md  = ($urandom_range(0, 9) == 0) ? WL : $urandom_range(0, WL - 1);
         run_instr(rop, rf3, rf7, fd, md, ra, rb, -1, tr);
         if (tr) begin
            trap_check(2);
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
